simon_game_ctrl: RTL and testbench
==================================

SIMON_GAME_CTRL -- requirements
Module: simon_game_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 3: consecutive equal synchronized samples required to change a debounced input.
REQ-002 Parameter BLINK_HALF, default 15: half-period, in clk cycles, of the game-over LED blink (2 Hz at 60 Hz).
REQ-003 Parameter CLEAR_CYCLES, default 2: cycles core_reset is held in CLEAR.
REQ-004 clk  in  1  single system clock (60 Hz); all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  raw start button, asynchronous to clk.
REQ-007 btn  in  4  raw player buttons, asynchronous to clk; bit i means colour i.
REQ-008 simon_turn, simon_num[1:0], simon_pressed, game_over  in  1/2/1/1  status from the Simon core.
REQ-009 core_reset  out  1  reset to the Simon core.
REQ-010 player_num  out  2  encoded colour of the last accepted press.
REQ-011 player_pressed  out  1  one-cycle strobe per accepted press.
REQ-012 led  out  4  lamp drive, bit i lights colour i.
REQ-013 score  out  5  completed rounds of the current game.
REQ-014 playing  out  1  high in state PLAY; win  out  1  high when the last game ended at full length.

Function
REQ-015 start and each btn bit shall pass a 2-flop synchronizer, then a debouncer; the debounced value changes only after DEB_CYCLES consecutive equal samples.
REQ-016 FSM states IDLE, CLEAR, PLAY, OVER; all outputs registered.
REQ-017 IDLE -> CLEAR on a debounced start 0->1 edge; otherwise stay.
REQ-018 CLEAR: core_reset=1, score=0, win=0, press lockout cleared, prev_turn=1; -> PLAY after CLEAR_CYCLES cycles.
REQ-019 PLAY: core_reset=0; -> OVER in the cycle after game_over is sampled 1.
REQ-020 OVER: core_reset=0 so the core's final state is retained; -> CLEAR on a debounced start 0->1 edge.
REQ-021 core_reset shall be 1 in IDLE and CLEAR, 0 in PLAY and OVER.
REQ-022 Press acceptance: in PLAY with simon_turn=0, a debounced btn change from 4'b0000 to a one-hot value shall, one cycle later, load player_num with its index and pulse player_pressed for exactly one cycle.
REQ-023 A debounced btn that is not one-hot, or becomes non-one-hot while held, shall assert lockout; no press is accepted until debounced btn returns to 4'b0000.
REQ-024 Presses while simon_turn=1, or outside PLAY, shall be ignored; releasing and re-pressing the same button shall produce a new strobe.
REQ-025 Raw btn edge to player_pressed latency shall be 2+DEB_CYCLES+1 cycles.
REQ-026 score shall increment by 1, saturating at 31, on each simon_turn 0->1 transition (vs. prev_turn) sampled in PLAY.
REQ-027 win shall be set when game_over and a simon_turn 0->1 transition are sampled in the same PLAY cycle; that round is also counted in score (16 on a win).
REQ-028 led: IDLE 0000; PLAY with simon_turn=1: one-hot(simon_num) when simon_pressed=1, else 0000; PLAY with simon_turn=0: debounced btn; OVER with win=1: 1111 steady; OVER with win=0: 1111/0000 toggling every BLINK_HALF cycles, starting at 1111 on OVER entry.
REQ-029 score and win shall hold their values through OVER until the next CLEAR.

Reset
REQ-030 On reset=1 at a clock edge: state=IDLE, core_reset=1, player_num=0, player_pressed=0, led=0000, score=0, playing=0, win=0, lockout=0, prev_turn=1, blink counter=0; synchronizer and debouncer state=0.
REQ-031 Reset mid-game shall abandon the game immediately; a pending strobe shall not be emitted.

Structure
REQ-032 Package simon_pkg shall hold the state enum and the default values of DEB_CYCLES, BLINK_HALF, CLEAR_CYCLES.
REQ-033 Sub-module btn_debounce (synchronizer plus debouncer, 1 bit) shall be instantiated 5 times: start and btn[3:0].

Verification
REQ-034 Reset, then a start pulse held 10 cycles -> CLEAR with core_reset=1 for 2 cycles -> PLAY with playing=1 and score=0.
REQ-035 In PLAY with simon_turn=0, btn=0100 held 8 cycles -> exactly one player_pressed strobe 6 cycles after the raw edge, with player_num=2; led=0100 while held.
REQ-036 btn=0011 pressed, then released to 0001, then released to 0000 -> no strobe until a fresh 0000->0001 press.
REQ-037 simon_turn toggles 0->1 three times -> score=3; game_over=1 alone -> OVER, win=0, led blinks with a 15-cycle half-period.
REQ-038 game_over and a simon_turn 0->1 transition in the same cycle -> OVER, win=1, score incremented, led=1111 steady; start press -> CLEAR, score=0, win=0.
REQ-039 reset asserted one cycle after a btn acceptance -> no strobe; all outputs at the REQ-030 values the next cycle.

Source files
------------

// File: rtl/simon_pkg.sv
// simon_pkg: shared state encoding, default timing constants and one-hot helpers
package simon_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_PLAY, ST_OVER} state_t;
  localparam int DEB_CYCLES_DEF   = 3;
  localparam int BLINK_HALF_DEF   = 15;
  localparam int CLEAR_CYCLES_DEF = 2;
  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
  endfunction
  function automatic logic [1:0] onehot_idx(input logic [3:0] v);
    return v[3] ? 2'd3 : v[2] ? 2'd2 : v[1] ? 2'd1 : 2'd0;
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer followed by a consecutive-sample debouncer
module btn_debounce #(
  parameter int DEB_CYCLES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_deb
);
  localparam int CW = $clog2(DEB_CYCLES) + 1;
  logic [1:0]    r_sync;
  logic          r_deb;
  logic [CW-1:0] r_cnt;
  // synchronize, then adopt the new level after DEB_CYCLES consecutive differing samples
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= 2'b00;
      r_deb  <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_sync <= {r_sync[0], i_raw};
      if (r_sync[1] == r_deb) r_cnt <= '0;
      else if (r_cnt == CW'(DEB_CYCLES - 1)) begin
        r_deb <= r_sync[1];
        r_cnt <= '0;
      end else r_cnt <= r_cnt + 1'b1;
    end
  end
  assign o_deb = r_deb;
endmodule

// File: rtl/simon_game_ctrl.sv
// simon_game_ctrl: game sequencing, press acceptance, scoring and lamp drive around a Simon core
module simon_game_ctrl import simon_pkg::*; #(
  parameter int DEB_CYCLES   = DEB_CYCLES_DEF,
  parameter int BLINK_HALF   = BLINK_HALF_DEF,
  parameter int CLEAR_CYCLES = CLEAR_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] btn,
  input  logic       simon_turn,
  input  logic [1:0] simon_num,
  input  logic       simon_pressed,
  input  logic       game_over,
  output logic       core_reset,
  output logic [1:0] player_num,
  output logic       player_pressed,
  output logic [3:0] led,
  output logic [4:0] score,
  output logic       playing,
  output logic       win
);
  localparam int CW = $clog2((BLINK_HALF > CLEAR_CYCLES) ? BLINK_HALF : CLEAR_CYCLES) + 1;
  state_t        r_state, w_state_n;
  logic [CW-1:0] r_cnt, w_cnt_n;
  logic          r_core_reset, r_pp, r_playing, r_win, r_lockout, r_prev_turn, r_start_prev;
  logic [1:0]    r_pnum;
  logic [3:0]    r_led, r_btn_prev;
  logic [4:0]    r_score;
  logic          w_start, w_start_rise, w_turn_rise, w_accept, w_win_n, w_lockout_n, w_prev_turn_n;
  logic [3:0]    w_btn, w_led_n;
  logic [4:0]    w_score_n;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
    .clk(clk), .reset(reset), .i_raw(start), .o_deb(w_start)
  );
  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_btn (
      .clk(clk), .reset(reset), .i_raw(btn[i]), .o_deb(w_btn[i])
    );
  end

  assign w_start_rise = w_start & ~r_start_prev;
  assign w_turn_rise  = simon_turn & ~r_prev_turn;
  assign w_accept     = (r_state == ST_PLAY) && !simon_turn && (r_btn_prev == 4'b0000)
                        && is_onehot(w_btn) && !r_lockout;

  // next state and next values of every registered output
  always_comb begin
    w_state_n     = r_state;
    w_cnt_n       = '0;
    w_score_n     = r_score;
    w_win_n       = r_win;
    w_prev_turn_n = r_prev_turn;
    w_lockout_n   = (w_btn == 4'b0000) ? 1'b0 : (r_lockout | ~is_onehot(w_btn));
    case (r_state)
      ST_IDLE:  w_state_n = w_start_rise ? ST_CLEAR : ST_IDLE;
      ST_CLEAR: begin
        w_cnt_n   = r_cnt + 1'b1;
        w_state_n = (r_cnt == CW'(CLEAR_CYCLES - 1)) ? ST_PLAY : ST_CLEAR;
      end
      ST_PLAY: begin
        w_prev_turn_n = simon_turn;
        w_score_n     = (w_turn_rise && r_score != 5'd31) ? r_score + 5'd1 : r_score;
        w_win_n       = game_over & w_turn_rise;
        w_state_n     = game_over ? ST_OVER : ST_PLAY;
      end
      ST_OVER: begin
        w_cnt_n   = (w_start_rise || r_cnt == CW'(BLINK_HALF - 1)) ? '0 : r_cnt + 1'b1;
        w_state_n = w_start_rise ? ST_CLEAR : ST_OVER;
      end
    endcase
    if (w_state_n == ST_CLEAR) begin
      w_score_n     = 5'd0;
      w_win_n       = 1'b0;
      w_lockout_n   = 1'b0;
      w_prev_turn_n = 1'b1;
    end
    w_led_n = (w_state_n == ST_PLAY) ? (simon_turn ? (simon_pressed ? 4'b0001 << simon_num : 4'b0000) : w_btn)
            : (w_state_n == ST_OVER) ? ((r_state != ST_OVER || w_win_n) ? 4'b1111
                                        : (r_cnt == CW'(BLINK_HALF - 1)) ? ~r_led : r_led)
            : 4'b0000;
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_core_reset <= 1'b1;
      r_pnum       <= 2'd0;
      r_pp         <= 1'b0;
      r_led        <= 4'b0000;
      r_score      <= 5'd0;
      r_playing    <= 1'b0;
      r_win        <= 1'b0;
      r_lockout    <= 1'b0;
      r_prev_turn  <= 1'b1;
      r_btn_prev   <= 4'b0000;
      r_start_prev <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_cnt        <= w_cnt_n;
      r_core_reset <= (w_state_n == ST_IDLE) || (w_state_n == ST_CLEAR);
      r_pnum       <= w_accept ? onehot_idx(w_btn) : r_pnum;
      r_pp         <= w_accept;
      r_led        <= w_led_n;
      r_score      <= w_score_n;
      r_playing    <= (w_state_n == ST_PLAY);
      r_win        <= w_win_n;
      r_lockout    <= w_lockout_n;
      r_prev_turn  <= w_prev_turn_n;
      r_btn_prev   <= w_btn;
      r_start_prev <= w_start;
    end
  end

  assign core_reset     = r_core_reset;
  assign player_num     = r_pnum;
  assign player_pressed = r_pp;
  assign led            = r_led;
  assign score          = r_score;
  assign playing        = r_playing;
  assign win            = r_win;
endmodule

// File: tb/tb_simon_game_ctrl.sv
// tb_simon_game_ctrl: directed scenarios with hand-computed expectations for simon_game_ctrl
module tb_simon_game_ctrl;
  logic       clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [3:0] btn = 4'b0000;
  logic       simon_turn = 1'b0, simon_pressed = 1'b0, game_over = 1'b0;
  logic [1:0] simon_num = 2'd0;
  logic       core_reset, player_pressed, playing, win;
  logic [1:0] player_num;
  logic [3:0] led;
  logic [4:0] score;
  int n_vec = 0, n_err = 0;

  simon_game_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .btn(btn), .simon_turn(simon_turn),
    .simon_num(simon_num), .simon_pressed(simon_pressed), .game_over(game_over),
    .core_reset(core_reset), .player_num(player_num), .player_pressed(player_pressed),
    .led(led), .score(score), .playing(playing), .win(win)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    n_vec++; if (core_reset !== 1'b1) begin n_err++; $display("FAIL reset core_reset got %b want 1", core_reset); end
    n_vec++; if (player_pressed !== 1'b0) begin n_err++; $display("FAIL reset player_pressed got %b want 0", player_pressed); end
    n_vec++; if (player_num !== 2'd0) begin n_err++; $display("FAIL reset player_num got %0d want 0", player_num); end
    n_vec++; if (led !== 4'b0000) begin n_err++; $display("FAIL reset led got %b want 0000", led); end
    n_vec++; if (score !== 5'd0) begin n_err++; $display("FAIL reset score got %0d want 0", score); end
    n_vec++; if (playing !== 1'b0) begin n_err++; $display("FAIL reset playing got %b want 0", playing); end
    n_vec++; if (win !== 1'b0) begin n_err++; $display("FAIL reset win got %b want 0", win); end
    reset = 1'b0;
  endtask

  // raw start rises before edge 1; debounced at edge 5, CLEAR at 6..7, PLAY from edge 8
  task automatic test_start(input string tag);
    start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      n_vec++; if (playing !== 1'(k >= 8)) begin n_err++; $display("FAIL %s playing k=%0d got %b want %b", tag, k, playing, k >= 8); end
      if (k == 7) begin
        n_vec++; if (core_reset !== 1'b1) begin n_err++; $display("FAIL %s clear core_reset got %b want 1", tag, core_reset); end
        n_vec++; if (score !== 5'd0) begin n_err++; $display("FAIL %s clear score got %0d want 0", tag, score); end
        n_vec++; if (win !== 1'b0) begin n_err++; $display("FAIL %s clear win got %b want 0", tag, win); end
      end
      if (k == 8) begin
        n_vec++; if (core_reset !== 1'b0) begin n_err++; $display("FAIL %s play core_reset got %b want 0", tag, core_reset); end
      end
    end
    start = 1'b0;
    repeat (8) tick();
  endtask

  task automatic test_no_press(input logic [3:0] b, input string tag);
    btn = b;
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_vec++; if (player_pressed !== 1'b0) begin n_err++; $display("FAIL %s stray strobe k=%0d got %b want 0", tag, k, player_pressed); end
    end
  endtask

  // strobe exactly at edge 6 after the raw edge, led follows debounced btn from edge 6
  task automatic test_press(input logic [3:0] b, input logic [1:0] num, input string tag);
    btn = b;
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_vec++; if (player_pressed !== 1'(k == 6)) begin n_err++; $display("FAIL %s strobe k=%0d got %b want %b", tag, k, player_pressed, k == 6); end
      if (k == 6) begin
        n_vec++; if (player_num !== num) begin n_err++; $display("FAIL %s player_num got %0d want %0d", tag, player_num, num); end
      end
      if (k == 5) begin
        n_vec++; if (led !== 4'b0000) begin n_err++; $display("FAIL %s early led got %b want 0000", tag, led); end
      end
      if (k == 8) begin
        n_vec++; if (led !== b) begin n_err++; $display("FAIL %s held led got %b want %b", tag, led, b); end
      end
    end
    btn = 4'b0000;
    repeat (8) tick();
    n_vec++; if (led !== 4'b0000) begin n_err++; $display("FAIL %s released led got %b want 0000", tag, led); end
  endtask

  task automatic test_lockout();
    test_no_press(4'b0011, "lock_0011");
    test_no_press(4'b0001, "lock_0001");
    test_no_press(4'b0000, "lock_0000");
    test_press(4'b0001, 2'd0, "lock_fresh");
  endtask

  task automatic test_score();
    simon_turn = 1'b1;
    tick();
    n_vec++; if (score !== 5'd1) begin n_err++; $display("FAIL score1 got %0d want 1", score); end
    simon_pressed = 1'b1; simon_num = 2'd3;
    tick();
    n_vec++; if (led !== 4'b1000) begin n_err++; $display("FAIL simon_led got %b want 1000", led); end
    simon_pressed = 1'b0;
    tick();
    n_vec++; if (led !== 4'b0000) begin n_err++; $display("FAIL simon_led_off got %b want 0000", led); end
    test_no_press(4'b0010, "turn_ignore");
    test_no_press(4'b0000, "turn_release");
    simon_turn = 1'b0; tick(); simon_turn = 1'b1; tick();
    n_vec++; if (score !== 5'd2) begin n_err++; $display("FAIL score2 got %0d want 2", score); end
    simon_turn = 1'b0; tick(); simon_turn = 1'b1; tick();
    n_vec++; if (score !== 5'd3) begin n_err++; $display("FAIL score3 got %0d want 3", score); end
    simon_turn = 1'b0; tick();
  endtask

  task automatic test_lose();
    game_over = 1'b1;
    tick();
    game_over = 1'b0;
    n_vec++; if (playing !== 1'b0) begin n_err++; $display("FAIL lose playing got %b want 0", playing); end
    n_vec++; if (win !== 1'b0) begin n_err++; $display("FAIL lose win got %b want 0", win); end
    n_vec++; if (score !== 5'd3) begin n_err++; $display("FAIL lose score got %0d want 3", score); end
    n_vec++; if (core_reset !== 1'b0) begin n_err++; $display("FAIL lose core_reset got %b want 0", core_reset); end
    for (int k = 1; k <= 31; k++) begin
      if (k > 1) tick();
      n_vec++; if (led !== ((((k - 1) / 15) % 2 == 0) ? 4'b1111 : 4'b0000)) begin
        n_err++; $display("FAIL blink k=%0d got %b want %b", k, led, (((k - 1) / 15) % 2 == 0) ? 4'b1111 : 4'b0000);
      end
    end
  endtask

  task automatic test_win();
    for (int i = 0; i < 15; i++) begin
      simon_turn = 1'b1; tick(); simon_turn = 1'b0; tick();
    end
    n_vec++; if (score !== 5'd15) begin n_err++; $display("FAIL win_pre score got %0d want 15", score); end
    simon_turn = 1'b1; game_over = 1'b1;
    tick();
    game_over = 1'b0; simon_turn = 1'b0;
    n_vec++; if (win !== 1'b1) begin n_err++; $display("FAIL win flag got %b want 1", win); end
    n_vec++; if (score !== 5'd16) begin n_err++; $display("FAIL win score got %0d want 16", score); end
    n_vec++; if (playing !== 1'b0) begin n_err++; $display("FAIL win playing got %b want 0", playing); end
    for (int k = 1; k <= 20; k++) begin
      n_vec++; if (led !== 4'b1111) begin n_err++; $display("FAIL win led k=%0d got %b want 1111", k, led); end
      tick();
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 33; i++) begin
      simon_turn = 1'b1; tick(); simon_turn = 1'b0; tick();
    end
    n_vec++; if (score !== 5'd31) begin n_err++; $display("FAIL saturate score got %0d want 31", score); end
    test_press(4'b1000, 2'd3, "press_1000");
  endtask

  // reset lands on the edge that would register the strobe
  task automatic test_reset_mid();
    btn = 4'b0001;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    n_vec++; if (player_pressed !== 1'b0) begin n_err++; $display("FAIL mid pressed got %b want 0", player_pressed); end
    n_vec++; if (player_num !== 2'd0) begin n_err++; $display("FAIL mid player_num got %0d want 0", player_num); end
    n_vec++; if (score !== 5'd0) begin n_err++; $display("FAIL mid score got %0d want 0", score); end
    n_vec++; if (core_reset !== 1'b1) begin n_err++; $display("FAIL mid core_reset got %b want 1", core_reset); end
    n_vec++; if (playing !== 1'b0) begin n_err++; $display("FAIL mid playing got %b want 0", playing); end
    n_vec++; if (led !== 4'b0000) begin n_err++; $display("FAIL mid led got %b want 0000", led); end
    n_vec++; if (win !== 1'b0) begin n_err++; $display("FAIL mid win got %b want 0", win); end
    reset = 1'b0;
    test_no_press(4'b0001, "post_reset_idle");
    btn = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_no_press(4'b0100, "idle_ignore");
    test_no_press(4'b0000, "idle_release");
    test_start("start1");
    test_press(4'b0100, 2'd2, "press_0100");
    test_press(4'b0100, 2'd2, "repress_0100");
    test_lockout();
    test_score();
    test_lose();
    test_start("start2");
    test_win();
    test_start("start3");
    test_saturate();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
